vga_timing_gen: RTL

Parametrised VGA raster timing generator: produces horizontal/vertical sync, data-enable, pixel coordinates and line/frame start strobes for any mode described by porch/sync/active parameters. It sits between the board clock and the pixel-colour logic. A clock enable lets a fast system clock (50 MHz) drive a slower pixel rate (25 MHz at ce every other cycle). Sync polarity is configurable per axis.

---
 rtl/vga_timing_gen.sv | 113 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock enable.
// Horizontal and vertical phase FSMs drive registered sync/de/coordinate/strobe outputs.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last position of each phase; a phase is left when its counter hits this value.
    localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_ACTIVE - 1);
    localparam logic [X_W-1:0] H_FP_END   = X_W'(H_ACTIVE + H_FP - 1);
    localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_ACTIVE - 1);
    localparam logic [Y_W-1:0] V_FP_END   = Y_W'(V_ACTIVE + V_FP - 1);
    localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);

    typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;

    logic [X_W-1:0] hCntReg, hCntNext;
    logic [Y_W-1:0] vCntReg, vCntNext;
    phase_t         hPhaseReg, hPhaseNext;
    phase_t         vPhaseReg, vPhaseNext;
    logic           hWrap, vWrap;

    always_comb begin
        hCntNext   = hCntReg;
        vCntNext   = vCntReg;
        hPhaseNext = hPhaseReg;
        vPhaseNext = vPhaseReg;
        hWrap      = (hCntReg == H_LAST);
        vWrap      = (vCntReg == V_LAST);
        if (ce) begin
            hCntNext = hWrap ? '0 : hCntReg + X_W'(1);
            case (hPhaseReg)
                PH_ACT:  if (hCntReg == H_ACT_END)  hPhaseNext = (H_FP > 0) ? PH_FP : PH_SYNC;
                PH_FP:   if (hCntReg == H_FP_END)   hPhaseNext = PH_SYNC;
                PH_SYNC: if (hCntReg == H_SYNC_END) hPhaseNext = (H_BP > 0) ? PH_BP : PH_ACT;
                PH_BP:   if (hWrap)                 hPhaseNext = PH_ACT;
                default:                            hPhaseNext = PH_ACT;
            endcase
            // Vertical machine only moves on the last pixel of a line.
            if (hWrap) begin
                vCntNext = vWrap ? '0 : vCntReg + Y_W'(1);
                case (vPhaseReg)
                    PH_ACT:  if (vCntReg == V_ACT_END)  vPhaseNext = (V_FP > 0) ? PH_FP : PH_SYNC;
                    PH_FP:   if (vCntReg == V_FP_END)   vPhaseNext = PH_SYNC;
                    PH_SYNC: if (vCntReg == V_SYNC_END) vPhaseNext = (V_BP > 0) ? PH_BP : PH_ACT;
                    PH_BP:   if (vWrap)                 vPhaseNext = PH_ACT;
                    default:                            vPhaseNext = PH_ACT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hCntReg     <= '0;
            vCntReg     <= '0;
            hPhaseReg   <= PH_ACT;
            vPhaseReg   <= PH_ACT;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hCntReg     <= hCntNext;
            vCntReg     <= vCntNext;
            hPhaseReg   <= hPhaseNext;
            vPhaseReg   <= vPhaseNext;
            // Strobes last exactly one clk even when ce drops the next cycle.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (ce) begin
                x           <= hCntReg;
                y           <= vCntReg;
                de          <= (hPhaseReg == PH_ACT) && (vPhaseReg == PH_ACT);
                hsync       <= (hPhaseReg == PH_SYNC) ? H_POL : ~H_POL;
                vsync       <= (vPhaseReg == PH_SYNC) ? V_POL : ~V_POL;
                line_start  <= (hCntReg == '0);
                frame_start <= (hCntReg == '0) && (vCntReg == '0);
            end
        end
    end

endmodule
